// File: rtl/raptor64_branch_verify.sv
// Raptor64 branch verify: in-order queue of fetch-time predictions,
// checked against EX resolution with redirect on mispredict.
module raptor64_branch_verify #(
  parameter int DEPTH = 4,
  parameter int AWID  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        advanceI,
  input  logic        iBranch,
  input  logic [63:0] pc,
  input  logic        predict_taken,
  input  logic        advanceX,
  input  logic        isxBranch,
  input  logic [63:0] xpc,
  input  logic        takb,
  input  logic [63:0] xbranch_target,
  output logic        mispredict,
  output logic [63:0] redirect_pc,
  output logic        q_empty,
  output logic        q_full,
  output logic        stall_if,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispredict_cnt,
  output logic        order_err
);

  logic [63:0]   pc_mem [DEPTH];
  logic          pr_mem [DEPTH];
  logic [AWID-1:0] wp, rp, wp_n, rp_n;
  logic [AWID:0]   count, cnt_n;

  logic push, pop, wrong, pc_bad, empty_pop;

  assign pop       = advanceX & isxBranch & ~q_empty;
  assign push      = advanceI & iBranch & (~q_full | pop);
  assign wrong     = pop & (pr_mem[rp] != takb);
  assign pc_bad    = pop & (pc_mem[rp] != xpc);
  assign empty_pop = advanceX & isxBranch & q_empty;
  assign stall_if  = iBranch & q_full & ~pop;

  // A wrong pop flushes the queue; a same-cycle push is wrong-path.
  always_comb begin
    wp_n  = wp;
    rp_n  = rp;
    cnt_n = count;
    if (wrong) begin
      wp_n  = '0;
      rp_n  = '0;
      cnt_n = '0;
    end else begin
      if (push) wp_n = wp + AWID'(1);
      if (pop)  rp_n = rp + AWID'(1);
      if (push & ~pop)      cnt_n = count + (AWID+1)'(1);
      else if (pop & ~push) cnt_n = count - (AWID+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wp] <= pc;
      pr_mem[wp] <= predict_taken;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp             <= '0;
      rp             <= '0;
      count          <= '0;
      q_empty        <= 1'b1;
      q_full         <= 1'b0;
      mispredict     <= 1'b0;
      redirect_pc    <= '0;
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
      order_err      <= 1'b0;
    end else begin
      wp         <= wp_n;
      rp         <= rp_n;
      count      <= cnt_n;
      q_empty    <= (cnt_n == '0);
      q_full     <= (cnt_n == (AWID+1)'(DEPTH));
      mispredict <= wrong;
      if (wrong)
        redirect_pc <= takb ? xbranch_target : xpc + 64'd4;
      if (pop)
        branch_cnt <= branch_cnt + 32'd1;
      if (wrong)
        mispredict_cnt <= mispredict_cnt + 32'd1;
      if (pc_bad | empty_pop)
        order_err <= 1'b1;
    end
  end

endmodule

// File: doc/raptor64_branch_verify.md
# raptor64_branch_verify

Execute-side companion to the IF-stage branch predictor in the Raptor64 core. It records every direction prediction issued at fetch in a small in-order queue, retires the oldest entry when the branch resolves in EX, and compares predicted against actual direction. On a wrong prediction it issues a one-cycle redirect to the fetch unit and keeps branch and misprediction statistics.

## Interface
Parameters:
- DEPTH, 4, number of in-flight prediction entries; power of two, 2..16
- AWID, 2, log2(DEPTH); pointer width

Ports:
- clk  in  1  core clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- advanceI  in  1  IF stage advances this cycle
- iBranch  in  1  instruction at pc is a conditional branch or trap
- pc  in  64  IF-stage program counter
- predict_taken  in  1  predictor direction for the branch at pc
- advanceX  in  1  EX stage advances this cycle
- isxBranch  in  1  instruction in EX is a conditional branch or trap
- xpc  in  64  EX-stage program counter
- takb  in  1  resolved direction in EX
- xbranch_target  in  64  resolved target when taken
- mispredict  out  1  one-cycle pulse: prediction was wrong
- redirect_pc  out  64  fetch address to use when mispredict=1
- q_empty  out  1  queue holds no entries
- q_full  out  1  queue holds DEPTH entries
- stall_if  out  1  combinational: iBranch & q_full & ~pop
- branch_cnt  out  32  resolved branches since reset
- mispredict_cnt  out  32  mispredictions since reset
- order_err  out  1  sticky: pop on empty or pc mismatch

## Operation
- Entry: {pc[63:0], predict_taken}. Storage is DEPTH-entry circular buffer; write pointer wp, read pointer rp (AWID bits, wrap modulo DEPTH), count (AWID+1 bits).
- push = advanceI & iBranch & (~q_full | pop). Writes entry at wp; wp+1.
- pop = advanceX & isxBranch & ~q_empty. Reads entry at rp; rp+1.
- Push and pop in the same cycle: both happen, count unchanged; legal when full (pop frees slot first) and when count=1.
- On pop: wrong = entry.pred != takb. If entry.pc != xpc, set order_err (still evaluate wrong).
- redirect_pc = takb ? xbranch_target : xpc + 64'd4 (64-bit add, wraps).
- On wrong pop: flush — wp, rp, count cleared to 0 at the same edge; a push in the same cycle is discarded (wrong-path fetch).
- advanceX & isxBranch with q_empty: no pop, no mispredict, no counter change, order_err set.
- branch_cnt +1 per pop; mispredict_cnt +1 per wrong pop; both wrap at 2^32.
- order_err clears only on rst.
- rst mid-operation: all queue contents discarded regardless of concurrent push/pop.

## Timing
- Reset values: mispredict=0, redirect_pc=0, q_empty=1, q_full=0, branch_cnt=0, mispredict_cnt=0, order_err=0, wp=rp=count=0.
- mispredict and redirect_pc registered: asserted in the cycle after the pop edge, for exactly one cycle; redirect_pc holds its last value otherwise.
- q_empty/q_full registered from next count; reflect push/pop/flush in the cycle after the edge.
- stall_if combinational from current q_full, iBranch, and pop; no added latency.
- Pop-to-redirect latency: 1 clock. Push-to-poppable latency: 1 clock (entry pushed at edge N is poppable in cycle N+1).
- advanceI=0 or advanceX=0 freezes the respective side; inputs ignored.

## Test plan
- Reset then push pc=0x100 pred=1, pop xpc=0x100 takb=1 -> mispredict stays 0, branch_cnt=1, q_empty=1 after pop.
- Push pc=0x200 pred=0, pop xpc=0x200 takb=1 target=0x400 -> next cycle mispredict=1 for one cycle, redirect_pc=0x400, mispredict_cnt=1; pred=1/takb=0 at xpc=0x200 -> redirect_pc=0x204.
- Fill DEPTH=4 entries -> q_full=1, stall_if=1 with iBranch=1; same-cycle push+pop while full -> count stays 4, stall_if=0, FIFO order preserved on subsequent pops.
- Three entries queued, oldest pops mispredicted while push asserted -> queue empty next cycle (q_empty=1), pushed entry discarded, later pop on empty sets order_err=1.
- Pop with xpc=0x300 against entry pc=0x2F0 -> order_err=1 and stays 1 until rst; rst asserted with 2 entries queued -> all outputs return to reset values next cycle.
- Wrap test: 10 push/pop pairs through DEPTH=4 -> pointers wrap, every entry returned in order, branch_cnt=10.
